// File: rtl/gpio_in_filter.sv
// GPIO input conditioner: two-flop synchronizer per pad, then a per-bit debounce
// filter that accepts a new level only after it persists, with edge pulses.
module gpio_in_filter #(
  parameter int WIDTH      = 16,
  parameter int DEB_CYCLES = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] PAD_IN,
  input  logic [WIDTH-1:0] BYPASS,
  output logic [WIDTH-1:0] IO_IN,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL,
  output logic             ANY_EDGE
);

  localparam int               CNT_W    = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [WIDTH-1:0] sync_s1;
  logic [WIDTH-1:0] sync_s2;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] differ;
  logic [WIDTH-1:0] at_last;
  logic [WIDTH-1:0] accept;

  // NOTE: every register uses non-blocking assignment so all flops sample
  // pre-edge values; blocking here would collapse s1/s2 into a single stage.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync_s1 <= '0;
      sync_s2 <= '0;
    end else begin
      sync_s1 <= PAD_IN;
      sync_s2 <= sync_s1;
    end
  end

  assign differ = sync_s2 ^ stable;

  // A bypassed bit accepts any difference immediately; a filtered bit only
  // once its counter has already seen DEB_CYCLES-1 differing edges.
  assign accept = differ & (BYPASS | at_last);

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    logic [CNT_W-1:0] count;

    assign at_last[g] = (count == CNT_LAST);

    // Clearing on acceptance (not just on agreement) keeps the count bounded.
    always_ff @(posedge CLK) begin
      if (RESET || BYPASS[g] || !differ[g] || at_last[g]) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end

    a_count_bounded : assert property (@(posedge CLK) disable iff (RESET)
      count <= CNT_LAST);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      stable   <= '0;
      RISE     <= '0;
      FALL     <= '0;
      ANY_EDGE <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (accept[i]) begin
          stable[i] <= sync_s2[i];
        end
      end
      RISE     <= accept & sync_s2;
      FALL     <= accept & ~sync_s2;
      ANY_EDGE <= |(RISE | FALL);
    end
  end

  assign IO_IN = stable;

  a_no_double_edge : assert property (@(posedge CLK) disable iff (RESET)
    (RISE & FALL) == '0);

endmodule

// File: doc/gpio_in_filter.md
GPIO_IN_FILTER -- requirements
Module: gpio_in_filter

Interface
REQ-001 Parameter WIDTH, default 16: number of GPIO input bits filtered.
REQ-002 Parameter DEB_CYCLES, default 4, legal range 1..255: consecutive cycles a synchronized level must persist before acceptance.
REQ-003 CLK  input  1  system clock (PLL output domain); single clock; all flops rising-edge.
REQ-004 RESET  input  1  reset, synchronous, active-high.
REQ-005 PAD_IN  input  WIDTH  raw pad input levels (iobuf C outputs), asynchronous to CLK.
REQ-006 BYPASS  input  WIDTH  per bit: 1 = synchronizer only, no debounce; 0 = debounced.
REQ-007 IO_IN  output  WIDTH  filtered levels to AHBGPIO IO_IN.
REQ-008 RISE  output  WIDTH  per-bit one-cycle pulse on accepted 0->1 change.
REQ-009 FALL  output  WIDTH  per-bit one-cycle pulse on accepted 1->0 change.
REQ-010 ANY_EDGE  output  1  registered OR-reduction of (RISE|FALL), for interrupt use.

Function
REQ-011 Each bit SHALL pass through a two-flop synchronizer (s1, s2); only s2 feeds the filter logic.
REQ-012 Each debounced bit SHALL hold a stable register (drives IO_IN) and a counter of width ceil(log2(DEB_CYCLES+1)).
REQ-013 On each edge, if s2 == stable, the counter SHALL clear to 0.
REQ-014 If s2 != stable and counter < DEB_CYCLES-1, the counter SHALL increment by 1.
REQ-015 If s2 != stable and counter == DEB_CYCLES-1, stable SHALL load s2, the counter SHALL clear, and the matching RISE/FALL bit SHALL assert for the next cycle only.
REQ-016 Latency: a clean level change applied before edge 0 SHALL appear on IO_IN after edge DEB_CYCLES+1 (edge 5 for DEB_CYCLES=4).
REQ-017 A pulse at s2 lasting fewer than DEB_CYCLES cycles SHALL NOT change IO_IN or raise RISE/FALL; returning to stable level restarts counting from 0.
REQ-018 Counter SHALL never exceed DEB_CYCLES-1 (no wrap-around).
REQ-019 Bypassed bit: stable SHALL load s2 every edge, counter held 0; RISE/FALL SHALL pulse on every s2 change (latency 2 edges from pad).
REQ-020 BYPASS change mid-count: 0->1 SHALL take effect on the next edge (stable <= s2, counter cleared, edge pulse if level differs); 1->0 SHALL start counting from 0.
REQ-021 RISE and FALL of one bit SHALL never assert in the same cycle; bits are fully independent.
REQ-022 ANY_EDGE SHALL be registered: high in the cycle after any RISE/FALL bit is high.

Reset
REQ-023 While RESET=1 at an edge: s1, s2, stable, counters, RISE, FALL, ANY_EDGE SHALL all become 0; IO_IN=0.
REQ-024 RESET asserted mid-count SHALL discard the partial count; after release a high pad SHALL be accepted as a fresh 0->1 change with full latency and a RISE pulse.
REQ-025 No output SHALL pulse in the first cycle after RESET deasserts.

Verification
REQ-026 DEB_CYCLES=4, BYPASS=0, PAD_IN[0] 0->1 held -> IO_IN[0]=1 after edge 5, RISE[0] one cycle, ANY_EDGE one cycle later.
REQ-027 PAD_IN[3] high 3 cycles then low -> IO_IN[3] stays 0, RISE[3]/FALL[3] never assert.
REQ-028 PAD_IN[5] bouncing 1,0,1,1,1,1 -> IO_IN[5] rises only after 4 consecutive synchronized 1s; exactly one RISE pulse.
REQ-029 BYPASS[7]=1, PAD_IN[7] toggles every cycle -> IO_IN[7] follows with 2-edge delay, RISE/FALL alternate every cycle.
REQ-030 PAD_IN=16'hFFFF, RESET pulsed at count 2 -> all outputs 0 during reset; IO_IN=16'hFFFF exactly DEB_CYCLES+2 edges after release with one RISE pulse per bit.
REQ-031 DEB_CYCLES=1 build: clean change -> IO_IN updates at edge 2; single-cycle glitch at s2 accepted (documented minimum-filter behaviour).
